riscv_dmem_wbuf: RTL and testbench
==================================

// Module: riscv_dmem_wbuf
// PURPOSE
//  Parametrised data-side posted write buffer with store-to-load forwarding.
//  Sits between the CPU data queue and the dcache/BIU request port. Stores are
//  acked on entry and drained in order; loads bypass buffered stores when no
//  address overlap exists. Store bus errors are reported imprecisely (sticky).
// PARAMETERS
//  XLEN   32    data width; byte lanes = XLEN/8
//  PLEN   XLEN  physical address width
//  DEPTH  4     store entries; power of 2, >=2
//  FWD    1     1: forward exact-match buffered store data to loads; 0: drain instead
// PORTS
//  clk_i          in   1     clock
//  rst_i          in   1     synchronous active-high reset
//  mem_req_i      in   1     CPU request valid
//  mem_rdy_o      out  1     request accepted when mem_req_i&mem_rdy_o
//  mem_adr_i      in   PLEN  request address
//  mem_size_i     in   biu_size_t  BYTE/HWORD/WORD(/DWORD if XLEN=64)
//  mem_we_i       in   1     1=store, 0=load
//  mem_d_i        in   XLEN  store data, already byte-lane positioned
//  mem_ack_o      out  1     store: same cycle as accept; load: response pulse
//  mem_err_o      out  1     load bus error, pulses instead of mem_ack_o
//  mem_q_o        out  XLEN  load data, byte-lane positioned, valid with mem_ack_o
//  drain_i        in   1     fence request; blocks new accepts while high
//  drain_rdy_o    out  1     buffer empty and downstream idle
//  st_err_o       out  1     sticky store error
//  st_err_adr_o   out  PLEN  address of first failing store
//  st_err_clr_i   in   1     clears st_err_o (clear wins over new error)
//  dn_req_o       out  1     downstream request; held until dn_ack_i|dn_err_i
//  dn_adr_o/dn_size_o/dn_we_o/dn_d_o  out  PLEN/biu_size_t/1/XLEN  stable while dn_req_o
//  dn_ack_i       in   1     downstream completion
//  dn_err_i       in   1     downstream error completion
//  dn_q_i         in   XLEN  load data, valid with dn_ack_i
// BEHAVIOUR
//  Reset: all entries invalid, FSMs IDLE; mem_rdy_o=0 in reset cycle then 1;
//   all other outputs 0, drain_rdy_o=1 after reset. Outstanding dn transfer is abandoned.
//  Buffer: circular FIFO, wr/rd ptrs log2(DEPTH)+1 bits; full when MSBs differ, low equal.
//  mem_rdy_o = !rst_i & !drain_i & up_state==IDLE & !(mem_we_i & full). Full uses
//   registered count; a pop in the same cycle does not admit a push.
//  Push and pop in same cycle: count unchanged, both pointers advance.
//  Upstream FSM (loads): IDLE, FWD, LDWAIT, LDDRAIN.
//   Load accept: word-compare adr[PLEN-1:log2(XLEN/8)] with all valid entries; youngest match decides:
//   no match -> LDWAIT (load issued downstream with priority over store drain);
//   match, FWD=1, identical adr and size -> FWD: mem_ack_o next cycle, mem_q_o=entry data;
//   other match -> LDDRAIN: wait until empty and dn idle, then LDWAIT.
//   LDWAIT: on dn_ack_i -> mem_ack_o=1, mem_q_o=dn_q_i (registered, +1 cycle) -> IDLE;
//   on dn_err_i -> mem_err_o pulse +1 cycle -> IDLE. Ack and err never both high.
//  Downstream FSM: DN_IDLE, DN_ST, DN_LD. In DN_IDLE: pending load (LDWAIT) issues
//   first, else non-empty buffer issues head store. Outputs registered. On dn_ack_i|dn_err_i
//   of a store: pop head; dn_req_o drops for at least one cycle between transfers.
//  Load issued in LDWAIT never overlaps a buffered store (guaranteed by the compare above).
//  Store error: dn_err_i on store -> entry still popped; if st_err_o==0 latch dn_adr_o,
//   set st_err_o; later errors do not overwrite the address until cleared.
//  drain_rdy_o = empty & dn_state==DN_IDLE & up_state==IDLE (combinational).
//  Minimum latencies: store accept->dn_req_o 1 cycle (empty buffer); load no-overlap
//   accept->dn_req_o 1 cycle; forward hit accept->mem_ack_o 1 cycle.
// TESTING
//  T1 reset: rst_i 3 cycles mid store drain -> dn_req_o=0, empty, drain_rdy_o=1, st_err_o=0.
//  T2 fill: 5 stores to 0x100..0x110, DEPTH=4 -> 4 acked, mem_rdy_o=0 on 5th until a pop; dn order 0x100,0x104,0x108,0x10C,0x110.
//  T3 forward: SW 0xDEADBEEF@0x200 (dn stalled), LW@0x200 -> mem_ack_o 1 cycle later, mem_q_o=0xDEADBEEF, no dn load.
//  T4 partial overlap: SW@0x300, LB@0x301 -> no ack until store completes, then load goes downstream.
//  T5 bypass: 2 stores buffered, LW@0x400 -> load issued before remaining stores; data returned from dn_q_i.
//  T6 errors: dn_err_i on store@0x500, then store@0x504 -> st_err_o=1, st_err_adr_o=0x500; st_err_clr_i clears; dn_err_i on load -> mem_err_o pulse, no mem_ack_o.

Source files
------------

// File: rtl/riscv_dmem_wbuf.sv
// Data-side posted write buffer with store-to-load forwarding.
// Stores are acknowledged on entry and drained in order to the downstream
// port. Loads bypass buffered stores unless their word overlaps a buffered
// store. Store bus errors are reported as a sticky flag with the first
// failing address.
// Size encoding on mem_size_i/dn_size_o: 0=BYTE, 1=HWORD, 2=WORD, 3=DWORD.
module riscv_dmem_wbuf #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PLEN  = XLEN,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned FWD   = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic            mem_req_i,
  output logic            mem_rdy_o,
  input  logic [PLEN-1:0] mem_adr_i,
  input  logic [2:0]      mem_size_i,
  input  logic            mem_we_i,
  input  logic [XLEN-1:0] mem_d_i,
  output logic            mem_ack_o,
  output logic            mem_err_o,
  output logic [XLEN-1:0] mem_q_o,

  input  logic            drain_i,
  output logic            drain_rdy_o,

  output logic            st_err_o,
  output logic [PLEN-1:0] st_err_adr_o,
  input  logic            st_err_clr_i,

  output logic            dn_req_o,
  output logic [PLEN-1:0] dn_adr_o,
  output logic [2:0]      dn_size_o,
  output logic            dn_we_o,
  output logic [XLEN-1:0] dn_d_o,
  input  logic            dn_ack_i,
  input  logic            dn_err_i,
  input  logic [XLEN-1:0] dn_q_i
);

  localparam int unsigned LSB = $clog2(XLEN / 8);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;

  typedef enum logic [1:0] {UP_IDLE, UP_FWD, UP_LDWAIT, UP_LDDRAIN} up_state_t;
  typedef enum logic [1:0] {DN_IDLE, DN_ST, DN_LD} dn_state_t;

  // Store entries
  logic [PLEN-1:0] ent_adr_q  [DEPTH];
  logic [2:0]      ent_size_q [DEPTH];
  logic [XLEN-1:0] ent_d_q    [DEPTH];

  logic [CW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_c;
  logic            full_c, empty_c;
  logic [PW-1:0]   wr_idx_c, rd_idx_c;

  up_state_t       up_state_q, up_state_d;
  logic [PLEN-1:0] ld_adr_q, ld_adr_d;
  logic [2:0]      ld_size_q, ld_size_d;
  logic            rsp_ack_q, rsp_ack_d;
  logic            rsp_err_q, rsp_err_d;
  logic [XLEN-1:0] rsp_q_q, rsp_q_d;

  dn_state_t       dn_state_q, dn_state_d;
  logic            dn_req_q, dn_req_d;
  logic [PLEN-1:0] dn_adr_q, dn_adr_d;
  logic [2:0]      dn_size_q, dn_size_d;
  logic            dn_we_q, dn_we_d;
  logic [XLEN-1:0] dn_d_q, dn_d_d;

  logic            st_err_q, st_err_d;
  logic [PLEN-1:0] st_err_adr_q, st_err_adr_d;

  logic            accept_c, push_c, ld_acc_c, pop_c, ld_issue_c;
  logic            hit_c, fwd_ok_c;
  logic [PW-1:0]   hit_idx_c, cmp_idx_c;

  // FIFO occupancy from the extended pointers
  always_comb begin
    wr_idx_c = wr_ptr_q[PW-1:0];
    rd_idx_c = rd_ptr_q[PW-1:0];
    count_c  = wr_ptr_q - rd_ptr_q;
    empty_c  = (wr_ptr_q == rd_ptr_q);
    full_c   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  end

  // Upstream handshake; full uses the registered count so a pop never admits a push
  always_comb begin
    mem_rdy_o   = !rst_i && !drain_i && (up_state_q == UP_IDLE) && !(mem_we_i && full_c);
    accept_c    = mem_req_i && mem_rdy_o;
    push_c      = accept_c && mem_we_i;
    ld_acc_c    = accept_c && !mem_we_i;
    pop_c       = (dn_state_q == DN_ST) && (dn_ack_i || dn_err_i);
    mem_ack_o   = push_c || rsp_ack_q;
    mem_err_o   = rsp_err_q;
    mem_q_o     = rsp_q_q;
    drain_rdy_o = empty_c && (dn_state_q == DN_IDLE) && (up_state_q == UP_IDLE);
  end

  // Word-address compare against valid entries, oldest to youngest so the youngest wins
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    cmp_idx_c = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      cmp_idx_c = rd_idx_c + PW'(k);
      if ((CW'(k) < count_c) &&
          (ent_adr_q[cmp_idx_c][PLEN-1:LSB] == mem_adr_i[PLEN-1:LSB])) begin
        hit_c     = 1'b1;
        hit_idx_c = cmp_idx_c;
      end
    end
    fwd_ok_c = (FWD != 0) && hit_c &&
               (ent_adr_q[hit_idx_c] == mem_adr_i) &&
               (ent_size_q[hit_idx_c] == mem_size_i);
  end

  // A load goes downstream straight from accept, or once LDWAIT sees the port idle
  always_comb begin
    ld_issue_c = (dn_state_q == DN_IDLE) &&
                 ((ld_acc_c && !hit_c) || (up_state_q == UP_LDWAIT));
  end

  // Upstream load FSM: next state and registered response
  always_comb begin
    up_state_d = up_state_q;
    ld_adr_d   = ld_adr_q;
    ld_size_d  = ld_size_q;
    rsp_ack_d  = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_q_d    = rsp_q_q;
    unique case (up_state_q)
      UP_IDLE: begin
        if (ld_acc_c) begin
          ld_adr_d  = mem_adr_i;
          ld_size_d = mem_size_i;
          if (!hit_c) begin
            up_state_d = UP_LDWAIT;
          end else if (fwd_ok_c) begin
            up_state_d = UP_FWD;
            rsp_ack_d  = 1'b1;
            rsp_q_d    = ent_d_q[hit_idx_c];
          end else begin
            up_state_d = UP_LDDRAIN;
          end
        end
      end
      UP_FWD: up_state_d = UP_IDLE;
      UP_LDWAIT: begin
        if (dn_state_q == DN_LD) begin
          if (dn_err_i) begin
            rsp_err_d  = 1'b1;
            up_state_d = UP_IDLE;
          end else if (dn_ack_i) begin
            rsp_ack_d  = 1'b1;
            rsp_q_d    = dn_q_i;
            up_state_d = UP_IDLE;
          end
        end
      end
      UP_LDDRAIN: begin
        if (empty_c && (dn_state_q == DN_IDLE)) up_state_d = UP_LDWAIT;
      end
      default: up_state_d = UP_IDLE;
    endcase
  end

  // Downstream FSM: pending load first, else head store; request drops between transfers
  always_comb begin
    dn_state_d = dn_state_q;
    dn_req_d   = dn_req_q;
    dn_adr_d   = dn_adr_q;
    dn_size_d  = dn_size_q;
    dn_we_d    = dn_we_q;
    dn_d_d     = dn_d_q;
    unique case (dn_state_q)
      DN_IDLE: begin
        dn_req_d = 1'b0;
        if (ld_issue_c) begin
          dn_req_d   = 1'b1;
          dn_we_d    = 1'b0;
          dn_adr_d   = (up_state_q == UP_LDWAIT) ? ld_adr_q  : mem_adr_i;
          dn_size_d  = (up_state_q == UP_LDWAIT) ? ld_size_q : mem_size_i;
          dn_state_d = DN_LD;
        end else if (!empty_c || push_c) begin
          dn_req_d   = 1'b1;
          dn_we_d    = 1'b1;
          dn_adr_d   = empty_c ? mem_adr_i  : ent_adr_q[rd_idx_c];
          dn_size_d  = empty_c ? mem_size_i : ent_size_q[rd_idx_c];
          dn_d_d     = empty_c ? mem_d_i    : ent_d_q[rd_idx_c];
          dn_state_d = DN_ST;
        end
      end
      DN_ST, DN_LD: begin
        if (dn_ack_i || dn_err_i) begin
          dn_req_d   = 1'b0;
          dn_state_d = DN_IDLE;
        end
      end
      default: begin
        dn_req_d   = 1'b0;
        dn_state_d = DN_IDLE;
      end
    endcase
  end

  // Sticky store error and pointer updates; clear wins over a new error
  always_comb begin
    st_err_d     = st_err_q;
    st_err_adr_d = st_err_adr_q;
    if (pop_c && dn_err_i && !st_err_q) begin
      st_err_d     = 1'b1;
      st_err_adr_d = dn_adr_q;
    end
    if (st_err_clr_i) st_err_d = 1'b0;
    wr_ptr_d = wr_ptr_q + CW'(push_c);
    rd_ptr_d = rd_ptr_q + CW'(pop_c);
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      up_state_q   <= UP_IDLE;
      ld_adr_q     <= '0;
      ld_size_q    <= '0;
      rsp_ack_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_q_q      <= '0;
      dn_state_q   <= DN_IDLE;
      dn_req_q     <= 1'b0;
      dn_adr_q     <= '0;
      dn_size_q    <= '0;
      dn_we_q      <= 1'b0;
      dn_d_q       <= '0;
      st_err_q     <= 1'b0;
      st_err_adr_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      up_state_q   <= up_state_d;
      ld_adr_q     <= ld_adr_d;
      ld_size_q    <= ld_size_d;
      rsp_ack_q    <= rsp_ack_d;
      rsp_err_q    <= rsp_err_d;
      rsp_q_q      <= rsp_q_d;
      dn_state_q   <= dn_state_d;
      dn_req_q     <= dn_req_d;
      dn_adr_q     <= dn_adr_d;
      dn_size_q    <= dn_size_d;
      dn_we_q      <= dn_we_d;
      dn_d_q       <= dn_d_d;
      st_err_q     <= st_err_d;
      st_err_adr_q <= st_err_adr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Entry payload storage, written on push
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      ent_adr_q[wr_idx_c]  <= mem_adr_i;
      ent_size_q[wr_idx_c] <= mem_size_i;
      ent_d_q[wr_idx_c]    <= mem_d_i;
    end
  end

  assign dn_req_o     = dn_req_q;
  assign dn_adr_o     = dn_adr_q;
  assign dn_size_o    = dn_size_q;
  assign dn_we_o      = dn_we_q;
  assign dn_d_o       = dn_d_q;
  assign st_err_o     = st_err_q;
  assign st_err_adr_o = st_err_adr_q;

endmodule

// File: tb/tb_riscv_dmem_wbuf.sv
// Directed bench for riscv_dmem_wbuf (XLEN=32, DEPTH=4, FWD=1).
module tb_riscv_dmem_wbuf;

  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_WORD = 3'd2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        mem_req_i, mem_rdy_o, mem_we_i, mem_ack_o, mem_err_o;
  logic [31:0] mem_adr_i, mem_d_i, mem_q_o;
  logic [2:0]  mem_size_i;
  logic        drain_i, drain_rdy_o;
  logic        st_err_o, st_err_clr_i;
  logic [31:0] st_err_adr_o;
  logic        dn_req_o, dn_we_o, dn_ack_i, dn_err_i;
  logic [31:0] dn_adr_o, dn_d_o, dn_q_i;
  logic [2:0]  dn_size_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_dmem_wbuf dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_req_i(mem_req_i), .mem_rdy_o(mem_rdy_o), .mem_adr_i(mem_adr_i),
    .mem_size_i(mem_size_i), .mem_we_i(mem_we_i), .mem_d_i(mem_d_i),
    .mem_ack_o(mem_ack_o), .mem_err_o(mem_err_o), .mem_q_o(mem_q_o),
    .drain_i(drain_i), .drain_rdy_o(drain_rdy_o),
    .st_err_o(st_err_o), .st_err_adr_o(st_err_adr_o), .st_err_clr_i(st_err_clr_i),
    .dn_req_o(dn_req_o), .dn_adr_o(dn_adr_o), .dn_size_o(dn_size_o),
    .dn_we_o(dn_we_o), .dn_d_o(dn_d_o),
    .dn_ack_i(dn_ack_i), .dn_err_i(dn_err_i), .dn_q_i(dn_q_i)
  );

  // One-cycle request attempt; returns the ready/ack seen in that cycle
  task automatic issue(input logic we, input logic [31:0] adr, input logic [2:0] sz,
                       input logic [31:0] d, output logic rdy, output logic ack);
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = we; mem_adr_i = adr; mem_size_i = sz; mem_d_i = d;
    #1;
    rdy = mem_rdy_o;
    ack = mem_ack_o;
    @(posedge clk); #1;
    mem_req_i = 1'b0; mem_we_i = 1'b0;
  endtask

  // Wait (bounded) for a downstream request and complete it
  task automatic serve_dn(input logic err, input logic [31:0] q, output logic [31:0] adr,
                          output logic we, output logic [31:0] d, output logic to);
    to = 1'b1; adr = '0; we = 1'b0; d = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dn_req_o) begin
        to = 1'b0; adr = dn_adr_o; we = dn_we_o; d = dn_d_o;
        break;
      end
    end
    if (!to) begin
      dn_ack_i = !err; dn_err_i = err; dn_q_i = q;
      @(posedge clk); #1;
      dn_ack_i = 1'b0; dn_err_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic rdy, ack;
    @(negedge clk); rst_i = 1'b0; #1;
    checks++; if (mem_rdy_o !== 1'b1) begin errors++; $display("FAIL rst_rdy: got %b exp 1", mem_rdy_o); end
    checks++; if (drain_rdy_o !== 1'b1 || dn_req_o !== 1'b0 || st_err_o !== 1'b0 || mem_ack_o !== 1'b0 || mem_err_o !== 1'b0) begin
      errors++; $display("FAIL rst_outs: drain_rdy=%b dn_req=%b st_err=%b ack=%b err=%b exp 1 0 0 0 0",
                         drain_rdy_o, dn_req_o, st_err_o, mem_ack_o, mem_err_o); end
    issue(1'b1, 32'h40, SZ_WORD, 32'h1234_5678, rdy, ack);
    checks++; if (rdy !== 1'b1 || ack !== 1'b1) begin errors++; $display("FAIL rst_st_acc: rdy=%b ack=%b exp 1 1", rdy, ack); end
    checks++; if (dn_req_o !== 1'b1 || dn_adr_o !== 32'h40 || dn_we_o !== 1'b1 || dn_d_o !== 32'h1234_5678) begin
      errors++; $display("FAIL st_latency: req=%b adr=%h we=%b d=%h exp 1 00000040 1 12345678", dn_req_o, dn_adr_o, dn_we_o, dn_d_o); end
    @(negedge clk); rst_i = 1'b1; #1;
    checks++; if (mem_rdy_o !== 1'b0) begin errors++; $display("FAIL rst_cycle_rdy: got %b exp 0", mem_rdy_o); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_i = 1'b0; #1;
    checks++; if (dn_req_o !== 1'b0 || drain_rdy_o !== 1'b1 || st_err_o !== 1'b0 || mem_rdy_o !== 1'b1) begin
      errors++; $display("FAIL rst_mid_drain: req=%b drain_rdy=%b st_err=%b rdy=%b exp 0 1 0 1", dn_req_o, drain_rdy_o, st_err_o, mem_rdy_o); end
  endtask

  task automatic test_fill();
    logic rdy, ack, we, to;
    logic [31:0] adr, d;
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 32'h100 + 32'(4 * i), SZ_WORD, 32'hA0 + 32'(i), rdy, ack);
      checks++;
      if (i < 4 && (rdy !== 1'b1 || ack !== 1'b1)) begin errors++; $display("FAIL fill_acc%0d: rdy=%b ack=%b exp 1 1", i, rdy, ack); end
      if (i == 4 && (rdy !== 1'b0 || ack !== 1'b0)) begin errors++; $display("FAIL fill_full: rdy=%b ack=%b exp 0 0", rdy, ack); end
    end
    serve_dn(1'b0, '0, adr, we, d, to);
    checks++; if (to || adr !== 32'h100 || we !== 1'b1 || d !== 32'hA0) begin
      errors++; $display("FAIL fill_dn0: to=%b adr=%h we=%b d=%h exp 0 00000100 1 000000a0", to, adr, we, d); end
    issue(1'b1, 32'h110, SZ_WORD, 32'hA4, rdy, ack);
    checks++; if (rdy !== 1'b1 || ack !== 1'b1) begin errors++; $display("FAIL fill_retry: rdy=%b ack=%b exp 1 1", rdy, ack); end
    for (int i = 1; i < 5; i++) begin
      serve_dn(1'b0, '0, adr, we, d, to);
      checks++; if (to || adr !== 32'h100 + 32'(4 * i) || we !== 1'b1 || d !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL fill_dn%0d: to=%b adr=%h we=%b d=%h exp adr %h", i, to, adr, we, d, 32'h100 + 32'(4 * i)); end
    end
    checks++; if (drain_rdy_o !== 1'b1) begin errors++; $display("FAIL fill_empty: drain_rdy=%b exp 1", drain_rdy_o); end
  endtask

  task automatic test_forward();
    logic rdy, ack, we, to;
    logic [31:0] adr, d;
    issue(1'b1, 32'h200, SZ_WORD, 32'hDEAD_BEEF, rdy, ack);
    issue(1'b0, 32'h200, SZ_WORD, '0, rdy, ack);
    checks++; if (rdy !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL fwd_acc: rdy=%b ack=%b exp 1 0", rdy, ack); end
    checks++; if (mem_ack_o !== 1'b1 || mem_q_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL fwd_data: ack=%b q=%h exp 1 deadbeef", mem_ack_o, mem_q_o); end
    checks++; if (dn_we_o !== 1'b1 || dn_adr_o !== 32'h200) begin
      errors++; $display("FAIL fwd_no_dnld: we=%b adr=%h exp 1 00000200", dn_we_o, dn_adr_o); end
    @(posedge clk); #1;
    checks++; if (mem_ack_o !== 1'b0) begin errors++; $display("FAIL fwd_pulse: ack=%b exp 0", mem_ack_o); end
    serve_dn(1'b0, '0, adr, we, d, to);
    checks++; if (to || adr !== 32'h200 || we !== 1'b1 || d !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL fwd_dn: to=%b adr=%h we=%b d=%h exp 0 00000200 1 deadbeef", to, adr, we, d); end
  endtask

  task automatic test_overlap();
    logic rdy, ack, we, to, seen;
    logic [31:0] adr, d;
    issue(1'b1, 32'h300, SZ_WORD, 32'h1122_3344, rdy, ack);
    issue(1'b0, 32'h301, SZ_BYTE, '0, rdy, ack);
    checks++; if (rdy !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL ovl_acc: rdy=%b ack=%b exp 1 0", rdy, ack); end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (mem_ack_o !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || drain_rdy_o !== 1'b0) begin
      errors++; $display("FAIL ovl_wait: early_ack=%b drain_rdy=%b exp 0 0", seen, drain_rdy_o); end
    serve_dn(1'b0, '0, adr, we, d, to);
    checks++; if (to || adr !== 32'h300 || we !== 1'b1) begin
      errors++; $display("FAIL ovl_st_first: to=%b adr=%h we=%b exp 0 00000300 1", to, adr, we); end
    checks++; if (mem_ack_o !== 1'b0) begin errors++; $display("FAIL ovl_no_ack: ack=%b exp 0", mem_ack_o); end
    serve_dn(1'b0, 32'h0000_3300, adr, we, d, to);
    checks++; if (to || adr !== 32'h301 || we !== 1'b0) begin
      errors++; $display("FAIL ovl_ld_dn: to=%b adr=%h we=%b exp 0 00000301 0", to, adr, we); end
    checks++; if (mem_ack_o !== 1'b1 || mem_q_o !== 32'h0000_3300 || mem_err_o !== 1'b0) begin
      errors++; $display("FAIL ovl_ld_rsp: ack=%b q=%h err=%b exp 1 00003300 0", mem_ack_o, mem_q_o, mem_err_o); end
  endtask

  task automatic test_bypass();
    logic rdy, ack, we, to;
    logic [31:0] adr, d;
    issue(1'b1, 32'h410, SZ_WORD, 32'h1, rdy, ack);
    issue(1'b1, 32'h414, SZ_WORD, 32'h2, rdy, ack);
    issue(1'b0, 32'h400, SZ_WORD, '0, rdy, ack);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL byp_acc: rdy=%b exp 1", rdy); end
    serve_dn(1'b0, '0, adr, we, d, to);
    checks++; if (to || adr !== 32'h410 || we !== 1'b1) begin
      errors++; $display("FAIL byp_st0: to=%b adr=%h we=%b exp 0 00000410 1", to, adr, we); end
    serve_dn(1'b0, 32'hCAFE_F00D, adr, we, d, to);
    checks++; if (to || adr !== 32'h400 || we !== 1'b0) begin
      errors++; $display("FAIL byp_ld_first: to=%b adr=%h we=%b exp 0 00000400 0", to, adr, we); end
    checks++; if (mem_ack_o !== 1'b1 || mem_q_o !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL byp_rsp: ack=%b q=%h exp 1 cafef00d", mem_ack_o, mem_q_o); end
    serve_dn(1'b0, '0, adr, we, d, to);
    checks++; if (to || adr !== 32'h414 || we !== 1'b1 || d !== 32'h2) begin
      errors++; $display("FAIL byp_st1: to=%b adr=%h we=%b d=%h exp 0 00000414 1 00000002", to, adr, we, d); end
    issue(1'b0, 32'h480, SZ_WORD, '0, rdy, ack);
    checks++; if (dn_req_o !== 1'b1 || dn_we_o !== 1'b0 || dn_adr_o !== 32'h480) begin
      errors++; $display("FAIL ld_latency: req=%b we=%b adr=%h exp 1 0 00000480", dn_req_o, dn_we_o, dn_adr_o); end
    serve_dn(1'b0, 32'h5A5A_5A5A, adr, we, d, to);
    checks++; if (to || mem_ack_o !== 1'b1 || mem_q_o !== 32'h5A5A_5A5A) begin
      errors++; $display("FAIL ld_empty_rsp: to=%b ack=%b q=%h exp 0 1 5a5a5a5a", to, mem_ack_o, mem_q_o); end
  endtask

  task automatic test_errors();
    logic rdy, ack, we, to;
    logic [31:0] adr, d;
    issue(1'b1, 32'h500, SZ_WORD, 32'h5, rdy, ack);
    issue(1'b1, 32'h504, SZ_WORD, 32'h6, rdy, ack);
    serve_dn(1'b1, '0, adr, we, d, to);
    checks++; if (to || adr !== 32'h500 || st_err_o !== 1'b1 || st_err_adr_o !== 32'h500) begin
      errors++; $display("FAIL sterr_first: to=%b adr=%h st_err=%b st_adr=%h exp 0 00000500 1 00000500", to, adr, st_err_o, st_err_adr_o); end
    serve_dn(1'b1, '0, adr, we, d, to);
    checks++; if (to || adr !== 32'h504 || st_err_o !== 1'b1 || st_err_adr_o !== 32'h500) begin
      errors++; $display("FAIL sterr_sticky: to=%b adr=%h st_err=%b st_adr=%h exp 0 00000504 1 00000500", to, adr, st_err_o, st_err_adr_o); end
    checks++; if (drain_rdy_o !== 1'b1) begin errors++; $display("FAIL sterr_popped: drain_rdy=%b exp 1", drain_rdy_o); end
    @(negedge clk); st_err_clr_i = 1'b1;
    @(posedge clk); #1; st_err_clr_i = 1'b0;
    checks++; if (st_err_o !== 1'b0) begin errors++; $display("FAIL sterr_clr: st_err=%b exp 0", st_err_o); end
    issue(1'b0, 32'h600, SZ_WORD, '0, rdy, ack);
    serve_dn(1'b1, 32'hFFFF_FFFF, adr, we, d, to);
    checks++; if (to || adr !== 32'h600 || mem_err_o !== 1'b1 || mem_ack_o !== 1'b0 || st_err_o !== 1'b0) begin
      errors++; $display("FAIL ld_err: to=%b adr=%h err=%b ack=%b st_err=%b exp 0 00000600 1 0 0", to, adr, mem_err_o, mem_ack_o, st_err_o); end
    @(posedge clk); #1;
    checks++; if (mem_err_o !== 1'b0) begin errors++; $display("FAIL ld_err_pulse: err=%b exp 0", mem_err_o); end
  endtask

  task automatic test_drain();
    logic rdy, ack;
    drain_i = 1'b1;
    issue(1'b1, 32'h700, SZ_WORD, 32'h7, rdy, ack);
    checks++; if (rdy !== 1'b0 || ack !== 1'b0 || drain_rdy_o !== 1'b1) begin
      errors++; $display("FAIL drain_block: rdy=%b ack=%b drain_rdy=%b exp 0 0 1", rdy, ack, drain_rdy_o); end
    drain_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0; mem_adr_i = '0; mem_size_i = '0;
    mem_d_i = '0; drain_i = 1'b0; st_err_clr_i = 1'b0;
    dn_ack_i = 1'b0; dn_err_i = 1'b0; dn_q_i = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_fill();
    test_forward();
    test_overlap();
    test_bypass();
    test_errors();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
